// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer: instruction-cycle sequencer for the 16-bit CPU.
// Produces one-hot FETCH/EXEC1/EXEC2 phase strobes, handles the instruction
// RAM ready handshake with a fetch timeout, STP halt, run/single-step debug
// control, a PC breakpoint, and saturating cycle/retired-instruction counters.
module cpu_phase_sequencer #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             RUN,
    input  logic             STEP,
    input  logic             E2,
    input  logic             STP,
    input  logic             MEM_READY,
    input  logic [15:0]      PC,
    input  logic [15:0]      BP_ADDR,
    input  logic             BP_EN,
    output logic             FETCH,
    output logic             EXEC1,
    output logic             EXEC2,
    output logic             IR_LOAD,
    output logic             HALTED,
    output logic             FAULT,
    output logic             BP_HIT,
    output logic [CNT_W-1:0] CYCLE_CNT,
    output logic [CNT_W-1:0] INSTR_CNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC1,
        S_EXEC2,
        S_DISPATCH,
        S_HALT,
        S_ERR
    } state_t;

    localparam logic [7:0]       TIMEOUT_W = 8'(TIMEOUT);
    localparam logic [7:0]       WAIT_ONE  = 8'd1;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             bp_skip_q, bp_skip_d;
    logic             bp_hit_q, bp_hit_d;
    logic             step_q;
    logic             step_rise;
    logic             fetch_q, fetch_d;
    logic             exec1_q, exec1_d;
    logic             exec2_q, exec2_d;
    logic             halted_q, halted_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instr_q, instr_d;
    logic             retire;
    logic             active;

    // Next-state, handshake bookkeeping, registered strobe decodes and counters.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        bp_skip_d = bp_skip_q;
        bp_hit_d  = bp_hit_q;
        retire    = 1'b0;
        step_rise = STEP & ~step_q;

        case (state_q)
            S_IDLE: begin
                if (RUN || step_rise) begin
                    state_d   = S_FETCH;
                    bp_skip_d = 1'b1;
                    bp_hit_d  = 1'b0;
                end
            end
            S_FETCH: begin
                if (MEM_READY) begin
                    state_d   = S_EXEC1;
                    wait_d    = '0;
                    bp_skip_d = 1'b0;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                    if (wait_d == TIMEOUT_W) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_EXEC1: begin
                if (STP) begin
                    state_d = S_HALT;
                    retire  = 1'b1;
                end else if (E2) begin
                    state_d = S_EXEC2;
                end else begin
                    state_d = S_DISPATCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC2: begin
                state_d = S_DISPATCH;
                retire  = 1'b1;
            end
            S_DISPATCH: begin
                if (BP_EN && (PC == BP_ADDR) && !bp_skip_q) begin
                    state_d  = S_IDLE;
                    bp_hit_d = 1'b1;
                end else if (RUN) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase

        fetch_d  = (state_d == S_FETCH);
        exec1_d  = (state_d == S_EXEC1);
        exec2_d  = (state_d == S_EXEC2);
        halted_d = (state_d == S_HALT);
        fault_d  = (state_d == S_ERR);

        active = (state_q == S_FETCH) || (state_q == S_EXEC1) ||
                 (state_q == S_EXEC2) || (state_q == S_DISPATCH);

        cycle_d = cycle_q;
        if (active && (cycle_q != CNT_MAX)) begin
            cycle_d = cycle_q + CNT_ONE;
        end

        instr_d = instr_q;
        if (retire && (instr_q != CNT_MAX)) begin
            instr_d = instr_q + CNT_ONE;
        end
    end

    // State, bookkeeping and output registers; reset returns everything to idle.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            bp_skip_q <= 1'b0;
            bp_hit_q  <= 1'b0;
            step_q    <= 1'b0;
            fetch_q   <= 1'b0;
            exec1_q   <= 1'b0;
            exec2_q   <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
            cycle_q   <= '0;
            instr_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bp_skip_q <= bp_skip_d;
            bp_hit_q  <= bp_hit_d;
            step_q    <= STEP;
            fetch_q   <= fetch_d;
            exec1_q   <= exec1_d;
            exec2_q   <= exec2_d;
            halted_q  <= halted_d;
            fault_q   <= fault_d;
            cycle_q   <= cycle_d;
            instr_q   <= instr_d;
        end
    end

    assign FETCH     = fetch_q;
    assign EXEC1     = exec1_q;
    assign EXEC2     = exec2_q;
    assign IR_LOAD   = fetch_q & MEM_READY;
    assign HALTED    = halted_q;
    assign FAULT     = fault_q;
    assign BP_HIT    = bp_hit_q;
    assign CYCLE_CNT = cycle_q;
    assign INSTR_CNT = instr_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Testbench for cpu_phase_sequencer: table vectors, randomized instruction
// streams expanded into expected phase traces, and hand-written corner cases.
module tb_cpu_phase_sequencer;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        RUN = 1'b0;
    logic        STEP = 1'b0;
    logic        E2 = 1'b0;
    logic        STP = 1'b0;
    logic        MEM_READY = 1'b0;
    logic [15:0] PC = '0;
    logic [15:0] BP_ADDR = '0;
    logic        BP_EN = 1'b0;
    logic        FETCH, EXEC1, EXEC2, IR_LOAD, HALTED, FAULT, BP_HIT;
    logic [31:0] CYCLE_CNT, INSTR_CNT;

    int passed = 0;
    int total = 0;
    bit pc_auto = 1'b0;

    // Expected strobe vectors {FETCH,EXEC1,EXEC2,IR_LOAD,HALTED,FAULT,BP_HIT}
    localparam bit [6:0] O_NONE = 7'b0000000;
    localparam bit [6:0] O_F    = 7'b1000000;
    localparam bit [6:0] O_FIR  = 7'b1001000;
    localparam bit [6:0] O_E1   = 7'b0100000;
    localparam bit [6:0] O_E2   = 7'b0010000;
    localparam bit [6:0] O_HALT = 7'b0000100;
    localparam bit [6:0] O_ERR  = 7'b0000010;
    localparam bit [6:0] O_BP   = 7'b0000001;

    typedef struct {
        bit       rst;
        bit       run;
        bit       step;
        bit       e2;
        bit       stp;
        bit       mr;
        bit [6:0] exp_o;
        int       cyc;
        int       ins;
    } vec_t;

    vec_t vecs[$];

    cpu_phase_sequencer #(.CNT_W(32), .TIMEOUT(15)) dut (
        .CLK(CLK), .RSTn(RSTn), .RUN(RUN), .STEP(STEP), .E2(E2), .STP(STP),
        .MEM_READY(MEM_READY), .PC(PC), .BP_ADDR(BP_ADDR), .BP_EN(BP_EN),
        .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2), .IR_LOAD(IR_LOAD),
        .HALTED(HALTED), .FAULT(FAULT), .BP_HIT(BP_HIT),
        .CYCLE_CNT(CYCLE_CNT), .INSTR_CNT(INSTR_CNT)
    );

    // Free-running clock, 10 time units per cycle
    always #5 CLK = ~CLK;

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic bit rb();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic bit [6:0] outs();
        return {FETCH, EXEC1, EXEC2, IR_LOAD, HALTED, FAULT, BP_HIT};
    endfunction

    function automatic vec_t mk(bit rst, bit run, bit step, bit e2, bit stp, bit mr,
                                bit [6:0] exp_o, int cyc, int ins);
        vec_t v;
        v.rst = rst; v.run = run; v.step = step; v.e2 = e2; v.stp = stp; v.mr = mr;
        v.exp_o = exp_o; v.cyc = cyc; v.ins = ins;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Advance one cycle; sample point is 1 unit after the rising edge.
    // When pc_auto is set, PC steps once per instruction during EXEC1 so that
    // DISPATCH already sees the next address.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (pc_auto && (EXEC1 === 1'b1)) PC = PC + 16'd1;
    endtask

    task automatic doReset();
        RSTn = 1'b0;
        RUN = 0; STEP = 0; E2 = 0; STP = 0; MEM_READY = 0;
        PC = '0; BP_ADDR = '0; BP_EN = 0; pc_auto = 0;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset_strobes", 64'(outs()), 64'(O_NONE));
        checkOutput("reset_counters", {CYCLE_CNT, INSTR_CNT}, 64'd0);
        RSTn = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge CLK);
        #1;
        RUN = v.run; STEP = v.step; E2 = v.e2; STP = v.stp; MEM_READY = v.mr;
        #1;
    endtask

    // Expand a random instruction stream into its expected per-cycle trace
    task automatic buildRandom(input int nprog);
        for (int p = 0; p < nprog; p++) begin
            int n;
            int cyc;
            int ins;
            n = int'($urandom_range(6, 1));
            cyc = 0;
            ins = 0;
            vecs.push_back(mk(1, 1, rb(), rb(), rb(), rb(), O_NONE, 0, 0));
            for (int i = 0; i < n; i++) begin
                int w;
                bit e;
                w = int'($urandom_range(4, 0));
                e = rb();
                for (int j = 0; j < w; j++) begin
                    vecs.push_back(mk(0, rb(), rb(), rb(), rb(), 0, O_F, cyc, ins));
                    cyc++;
                end
                vecs.push_back(mk(0, rb(), rb(), rb(), rb(), 1, O_FIR, cyc, ins));
                cyc++;
                vecs.push_back(mk(0, rb(), rb(), e, 0, rb(), O_E1, cyc, ins));
                cyc++;
                if (e) begin
                    vecs.push_back(mk(0, rb(), rb(), rb(), rb(), rb(), O_E2, cyc, ins));
                    cyc++;
                end
                ins++;
                vecs.push_back(mk(0, (i != n - 1), rb(), rb(), rb(), rb(), O_NONE, cyc, ins));
                cyc++;
            end
            vecs.push_back(mk(0, 0, 0, rb(), rb(), rb(), O_NONE, cyc, ins));
        end
    endtask

    initial begin
        int fcount;
        int irl;
        bit hit;
        bit ok;
        bit saw_e2;

        // Free run, four plain instructions; RUN drops during the last one
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, O_NONE, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, O_FIR, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, O_E1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, O_NONE, 2, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, O_FIR, 3, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, O_E1, 4, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, O_NONE, 5, 2));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, O_FIR, 6, 2));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, O_E1, 7, 2));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, O_NONE, 8, 3));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, O_FIR, 9, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, O_E1, 10, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, O_NONE, 11, 4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, O_NONE, 12, 4));
        // Single step with EXEC2, then a STEP held for five cycles
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, O_NONE, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, O_FIR, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, O_E1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, O_E2, 2, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, O_NONE, 3, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, O_NONE, 4, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, O_FIR, 4, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, O_E1, 5, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, O_NONE, 6, 2));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, O_NONE, 7, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, O_NONE, 7, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, O_NONE, 7, 2));

        buildRandom(20);

        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].rst) doReset();
            applyStimulus(vecs[k]);
            checkOutput($sformatf("row%0d_strobes", k), 64'(outs()), 64'(vecs[k].exp_o));
            checkOutput($sformatf("row%0d_cycle_cnt", k), 64'(CYCLE_CNT), 64'(vecs[k].cyc));
            checkOutput($sformatf("row%0d_instr_cnt", k), 64'(INSTR_CNT), 64'(vecs[k].ins));
        end

        // Breakpoint at 0x0005, then resume without retriggering
        doReset();
        BP_EN = 1; BP_ADDR = 16'h0005; MEM_READY = 1; pc_auto = 1; RUN = 1;
        hit = 0;
        for (int i = 0; i < 80 && !hit; i++) begin
            tick();
            if (BP_HIT === 1'b1) begin
                hit = 1;
                RUN = 0;
            end
        end
        checkOutput("bp_hit_seen", 64'(hit), 64'd1);
        checkOutput("bp_stop_strobes", 64'(outs()), 64'(O_BP));
        checkOutput("bp_stop_pc", 64'(PC), 64'h5);
        checkOutput("bp_stop_instr", 64'(INSTR_CNT), 64'd5);
        checkOutput("bp_stop_cycle", 64'(CYCLE_CNT), 64'd15);
        repeat (3) tick();
        checkOutput("bp_hold", 64'(outs()), 64'(O_BP));
        RUN = 1;
        tick();
        checkOutput("bp_resume_fetch", 64'(outs()), 64'(O_FIR));
        repeat (5) tick();
        checkOutput("bp_resume_instr", 64'(INSTR_CNT), 64'd7);
        checkOutput("bp_no_retrigger", 64'(BP_HIT), 64'd0);
        checkOutput("bp_resume_pc", 64'(PC), 64'h7);
        RUN = 0;
        pc_auto = 0;

        // STP and E2 together: HALT wins, no EXEC2, sticky until reset
        doReset();
        RUN = 1; MEM_READY = 1; E2 = 1; STP = 1;
        saw_e2 = 0;
        repeat (3) begin
            tick();
            if (EXEC2 === 1'b1) saw_e2 = 1;
        end
        checkOutput("halt_state", 64'(outs()), 64'(O_HALT));
        checkOutput("halt_instr", 64'(INSTR_CNT), 64'd1);
        checkOutput("halt_cycle", 64'(CYCLE_CNT), 64'd2);
        ok = 1;
        for (int i = 0; i < 20; i++) begin
            RUN = rb();
            STEP = rb();
            tick();
            if (outs() !== O_HALT) ok = 0;
            if (EXEC2 === 1'b1) saw_e2 = 1;
        end
        checkOutput("halt_hold", 64'(ok), 64'd1);
        checkOutput("halt_no_exec2", 64'(saw_e2), 64'd0);
        RSTn = 0;
        #1;
        checkOutput("halt_reset_clears", 64'(outs()), 64'(O_NONE));

        // MEM_READY never arrives: fault after exactly TIMEOUT fetch cycles
        doReset();
        RUN = 1; MEM_READY = 0;
        fcount = 0;
        irl = 0;
        for (int i = 0; i < 40 && (FAULT !== 1'b1); i++) begin
            tick();
            if (FETCH === 1'b1) fcount++;
            if (IR_LOAD === 1'b1) irl++;
        end
        checkOutput("timeout_fetch_cycles", 64'(fcount), 64'd15);
        checkOutput("timeout_fault", 64'(outs()), 64'(O_ERR));
        checkOutput("timeout_no_ir_load", 64'(irl), 64'd0);
        repeat (5) tick();
        checkOutput("timeout_sticky", 64'(outs()), 64'(O_ERR));

        // Three wait states: four FETCH cycles and one IR_LOAD pulse
        doReset();
        RUN = 1; MEM_READY = 0;
        fcount = 0;
        irl = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (FETCH === 1'b1) begin
                fcount++;
                MEM_READY = (fcount >= 4);
                RUN = 0;
            end else begin
                MEM_READY = 0;
            end
            #1;
            if (IR_LOAD === 1'b1) irl++;
        end
        checkOutput("wait3_fetch_cycles", 64'(fcount), 64'd4);
        checkOutput("wait3_ir_load_pulses", 64'(irl), 64'd1);
        checkOutput("wait3_instr", 64'(INSTR_CNT), 64'd1);
        checkOutput("wait3_cycle", 64'(CYCLE_CNT), 64'd6);

        // Asynchronous reset during EXEC2 clears outputs before any clock edge
        doReset();
        RUN = 1; MEM_READY = 1; E2 = 1;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            if (EXEC2 === 1'b1) hit = 1;
        end
        checkOutput("arst_reached_exec2", 64'(hit), 64'd1);
        #2;
        RSTn = 0;
        #1;
        checkOutput("arst_strobes", 64'(outs()), 64'(O_NONE));
        checkOutput("arst_counters", {CYCLE_CNT, INSTR_CNT}, 64'd0);
        RUN = 0; E2 = 0;
        #3;
        RSTn = 1;
        tick();
        checkOutput("arst_idle", 64'(outs()), 64'(O_NONE));
        RUN = 1;
        tick();
        checkOutput("arst_restart_fetch", 64'(outs()), 64'(O_FIR));
        RUN = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
